// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : RV32I load/store unit; one valid/ready bus transaction per op,
//            with byte-enable/lane formatting and load sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] c_CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] c_CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] c_CAUSE_ILLEGAL  = 2'b11;
  localparam bit         c_TO_EN          = (TIMEOUT != 0);
  // Last counter value before the bus gives up; counter is 8 bits wide.
  localparam logic [7:0] c_TO_LAST        = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_cause;

  logic        w_req, w_illegal, w_misaligned, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_fmt_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  assign w_req     = req_valid & (load | store);
  assign w_timeout = c_TO_EN && (r_cnt == c_TO_LAST);

  always_comb begin
    w_illegal = 1'b0;
    if (load & store)
      w_illegal = 1'b1;
    else if (load)
      w_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    else if (store)
      w_illegal = funct3[2] || (funct3[1:0] == 2'b11);
  end

  always_comb begin
    w_misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   w_misaligned = addr[0];
      2'b10:   w_misaligned = (addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  // Loads use the same byte mask as stores but never drive write data.
  always_comb begin
    w_be        = 4'b0000;
    w_fmt_wdata = '0;
    case (funct3[1:0])
      2'b00: begin
        w_be        = 4'b0001 << addr[1:0];
        w_fmt_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_be        = addr[1] ? 4'b1100 : 4'b0011;
        w_fmt_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_fmt_wdata = wdata;
      end
    endcase
    if (load)
      w_fmt_wdata = '0;
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {24'd0, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_ext = {16'd0, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req)
          w_state_nxt = (w_illegal || w_misaligned) ? S_ERR : S_BUS;
      end
      S_BUS: begin
        if (mem_ready)
          w_state_nxt = S_RESP;
        else if (w_timeout)
          w_state_nxt = S_ERR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cause  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            if (w_illegal)
              r_cause <= c_CAUSE_ILLEGAL;
            else if (w_misaligned)
              r_cause <= c_CAUSE_MISALIGN;
            else begin
              r_addr   <= addr;
              r_funct3 <= funct3;
              r_we     <= store;
              r_be     <= w_be;
              r_wdata  <= w_fmt_wdata;
            end
          end
        end
        S_BUS: begin
          if (mem_ready)
            r_rdata <= r_we ? '0 : w_load_ext;
          else if (w_timeout)
            r_cause <= c_CAUSE_TIMEOUT;
          else
            r_cnt <= r_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Bus and result outputs are gated by state so they read zero outside use.
  assign busy      = (r_state != S_IDLE);
  assign mem_valid = (r_state == S_BUS);
  assign mem_we    = mem_valid & r_we;
  assign mem_addr  = mem_valid ? {r_addr[31:2], 2'b00} : '0;
  assign mem_be    = mem_valid ? r_be : '0;
  assign mem_wdata = mem_valid ? r_wdata : '0;
  assign done      = (r_state == S_RESP) || (r_state == S_ERR);
  assign err       = (r_state == S_ERR);
  assign err_cause = err ? r_cause : '0;
  assign rdata     = (r_state == S_RESP) ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed self-checking bench for lsu with a per-cycle reference.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lsu;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, load, store, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, mem_valid, mem_we;
  logic [1:0]  err_cause;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .load(load), .store(store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .err(err), .err_cause(err_cause), .mem_valid(mem_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic        e_busy, e_done, e_err, e_valid, e_we;
  logic [1:0]  e_cause;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;
  int          n_checks = 0, n_fail = 0;
  bit          chk_en = 0;
  logic [31:0] cap_rdata, cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  int          cap_valid_cycles = 0, cap_done_count = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(e_busy));
      cmp("done", 32'(done), 32'(e_done));
      cmp("err", 32'(err), 32'(e_err));
      cmp("err_cause", 32'(err_cause), 32'(e_cause));
      cmp("rdata", rdata, e_rdata);
      cmp("mem_valid", 32'(mem_valid), 32'(e_valid));
      cmp("mem_we", 32'(mem_we), 32'(e_we));
      cmp("mem_addr", mem_addr, e_addr);
      cmp("mem_be", 32'(mem_be), 32'(e_be));
      cmp("mem_wdata", mem_wdata, e_wdata);
      if (mem_valid) begin
        cap_valid_cycles++;
        cap_addr  = mem_addr;
        cap_be    = mem_be;
        cap_wdata = mem_wdata;
      end
      if (done) begin
        cap_done_count++;
        cap_rdata = rdata;
      end
    end
  end

  // ---------------- reference model (arithmetic view of the op rules)
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_illegal(input bit ld, input bit st, input logic [2:0] f3);
    if (ld && st) return 1'b1;
    if (ld) return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    return !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int m;
    m = ((1 << nbytes(f3)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (nbytes(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
    logic [31:0] v, mask;
    int bits;
    bits = 8 * nbytes(f3);
    v    = word >> (8 * (a % 4));
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    v    = v & mask;
    if (f3[2] == 1'b0 && bits < 32 && ((v >> (bits - 1)) & 32'd1) == 32'd1)
      v = v | ~mask;
    return v;
  endfunction

  task automatic set_idle();
    e_busy = 0; e_done = 0; e_err = 0; e_cause = 0; e_rdata = 0;
    e_valid = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
  endtask

  // Present one op in an IDLE cycle and step it to the following IDLE cycle.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int rdy_delay, input logic [31:0] word);
    bit ill, mis, tout;
    int bus_cycles;
    req_valid = 1; load = ld; store = st; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    ill = is_illegal(ld, st, f3);
    mis = !ill && is_misaligned(f3, a);
    if (ill || mis) begin
      req_valid = 0;
      set_idle();
      e_busy = 1; e_done = 1; e_err = 1; e_cause = ill ? 2'b11 : 2'b01;
    end else begin
      tout       = (rdy_delay >= TO);
      bus_cycles = tout ? TO : rdy_delay + 1;
      e_busy = 1; e_valid = 1; e_we = st; e_addr = a & 32'hFFFF_FFFC;
      e_be   = model_be(f3, a);
      e_wdata = st ? model_wdata(f3, wd) : 32'd0;
      for (int i = 0; i < bus_cycles; i++) begin
        mem_ready = (!tout && i == rdy_delay);
        mem_rdata = mem_ready ? word : $urandom;
        @(posedge clk); #1;
      end
      mem_ready = 0; req_valid = 0;
      set_idle();
      e_busy = 1; e_done = 1;
      if (tout) begin
        e_err = 1; e_cause = 2'b10;
      end else begin
        e_rdata = st ? 32'd0 : model_load(f3, a, word);
      end
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  int v0, d0;

  initial begin
    rst = 1; req_valid = 0; load = 0; store = 0; funct3 = 0;
    addr = 0; wdata = 0; mem_ready = 0; mem_rdata = 0;
    set_idle();
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // LB sign-extending the top byte lane
    v0 = cap_valid_cycles;
    run_op(1, 0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_0000);
    cmp("lb_be", 32'(cap_be), 32'h8);
    cmp("lb_rdata", cap_rdata, 32'hFFFF_FF80);
    cmp("lb_bus_cycles", 32'(cap_valid_cycles - v0), 32'd1);

    run_op(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 32'h0);
    cmp("sh_addr", cap_addr, 32'h0000_2000);
    cmp("sh_be", 32'(cap_be), 32'hC);
    cmp("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    cmp("sh_rdata", cap_rdata, 32'h0);

    v0 = cap_valid_cycles;
    run_op(1, 0, 3'b010, 32'h0000_3001, 32'h0, 0, 32'h0);
    run_op(1, 0, 3'b011, 32'h0000_3000, 32'h0, 0, 32'h0);
    cmp("err_no_bus", 32'(cap_valid_cycles - v0), 32'd0);

    v0 = cap_valid_cycles;
    run_op(1, 0, 3'b101, 32'h0000_4002, 32'h0, 3, 32'hF00D_1234);
    cmp("lhu_rdata", cap_rdata, 32'h0000_F00D);
    cmp("lhu_bus_cycles", 32'(cap_valid_cycles - v0), 32'd4);

    v0 = cap_valid_cycles;
    run_op(1, 0, 3'b010, 32'h0000_5000, 32'h0, 100, 32'h0);
    cmp("timeout_bus_cycles", 32'(cap_valid_cycles - v0), 32'd4);

    run_op(0, 1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 1, 32'h0);
    cmp("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    cmp("sb_be", 32'(cap_be), 32'h2);
    run_op(1, 0, 3'b100, 32'h0000_7002, 32'h0, 0, 32'h11AA_2233);
    cmp("lbu_rdata", cap_rdata, 32'h0000_00AA);
    run_op(1, 0, 3'b001, 32'h0000_8000, 32'h0, 2, 32'h0000_8001);
    cmp("lh_rdata", cap_rdata, 32'hFFFF_8001);
    run_op(0, 1, 3'b010, 32'h0000_9000, 32'hCAFE_F00D, 0, 32'h0);
    run_op(1, 0, 3'b010, 32'h0000_A000, 32'h0, 1, 32'hDEAD_BEEF);
    run_op(1, 0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h7FFF_0000);
    run_op(0, 1, 3'b100, 32'h0000_B000, 32'h1, 0, 32'h0);
    run_op(0, 1, 3'b011, 32'h0000_B000, 32'h1, 0, 32'h0);
    run_op(1, 1, 3'b010, 32'h0000_B000, 32'h1, 0, 32'h0);
    run_op(1, 0, 3'b110, 32'h0000_B000, 32'h0, 0, 32'h0);
    run_op(0, 1, 3'b001, 32'h0000_0101, 32'h1, 0, 32'h0);

    // Request with neither load nor store stays idle
    req_valid = 1; load = 0; store = 0; funct3 = 3'b010; addr = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 0;

    // Reset while the bus is waiting; a late ready must be ignored
    d0 = cap_done_count;
    req_valid = 1; load = 1; store = 0; funct3 = 3'b010; addr = 32'h0000_C000;
    @(posedge clk); #1;
    e_busy = 1; e_valid = 1; e_addr = 32'h0000_C000; e_be = 4'hF;
    mem_ready = 0; rst = 1;
    @(posedge clk); #1;
    set_idle();
    rst = 0; req_valid = 0; mem_ready = 1; mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp("rst_no_done", 32'(cap_done_count - d0), 32'd0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
